// File: rtl/ram_arbiter_if.sv
// Word-addressed RAM handshake bundle shared by the two requesters and the RAM port.
// The master modport drives a request; the slave modport answers it.
interface ram_arbiter_if;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] wdat;
  logic [29:0] adr;
  logic [31:0] rdat;
  logic        ack;
  logic        err;

  modport master (output stb, we, sel, wdat, adr, input rdat, ack);
  modport slave  (input stb, we, sel, wdat, adr, output rdat, ack, err);
endinterface

// File: rtl/ram_arbiter.sv
// Two-master round-robin arbiter in front of a single-port RAM, one access in flight,
// with a per-access watchdog that aborts unacknowledged accesses and flags an error.
module ram_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic clk_i,
  input logic rst_i,
  ram_arbiter_if.slave  m0,
  ram_arbiter_if.slave  m1,
  ram_arbiter_if.master s
);
  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [7:0] CNT_MAX  = '1;

  state_t     state, state_n;
  logic       grant, grant_n;
  logic       prio, prio_n;
  logic [7:0] cnt, cnt_n;

  logic busy;
  logic g_stb;
  logic to_hit;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      grant <= 1'b0;
      prio  <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      prio  <= prio_n;
      cnt   <= cnt_n;
    end
  end

  assign busy  = (state == BUSY);
  assign g_stb = grant ? m1.stb : m0.stb;
  // An ack in the same cycle beats the watchdog; a withdrawn strobe is never flagged.
  assign to_hit = busy & g_stb & ~s.ack & (cnt == CNT_LAST);

  always_comb begin
    s.stb  = busy & g_stb & ~to_hit;
    s.we   = busy & (grant ? m1.we : m0.we);
    s.sel  = busy ? (grant ? m1.sel  : m0.sel)  : '0;
    s.wdat = busy ? (grant ? m1.wdat : m0.wdat) : '0;
    s.adr  = busy ? (grant ? m1.adr  : m0.adr)  : '0;

    m0.ack  = busy & ~grant & s.ack;
    m1.ack  = busy &  grant & s.ack;
    m0.err  = to_hit & ~grant;
    m1.err  = to_hit &  grant;
    m0.rdat = s.rdat;
    m1.rdat = s.rdat;
  end

  always_comb begin
    state_n = state;
    grant_n = grant;
    prio_n  = prio;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (m0.stb | m1.stb) begin
          state_n = BUSY;
          grant_n = (m0.stb & m1.stb) ? prio : m1.stb;
          cnt_n   = '0;
        end
      end
      BUSY: begin
        if (s.ack) begin
          state_n = IDLE;
          prio_n  = ~grant;
        end else if (!g_stb) begin
          state_n = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_n = IDLE;
          prio_n  = ~grant;
        end else if (cnt != CNT_MAX) begin
          cnt_n = cnt + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a one-cycle-latency RAM model, a scoreboard of expected
// accesses checked on every ack, a table of single accesses and hand-written corner cases.
module tb_ram_arbiter;
  typedef struct {
    bit          mst;
    bit          we;
    logic [3:0]  sel;
    logic [29:0] adr;
    logic [31:0] dat;
    logic [31:0] rd;
  } acc_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  acc_t sbq[$];
  acc_t tbl[9];

  ram_arbiter_if m0_bus();
  ram_arbiter_if m1_bus();
  ram_arbiter_if s_bus();

  ram_arbiter #(.TIMEOUT(4)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .m0(m0_bus.slave),
    .m1(m1_bus.slave),
    .s(s_bus.master)
  );

  always #5 clk = ~clk;

  // RAM model: acks one cycle after seeing stb, unless noack holds it silent.
  logic [31:0] mem [64];
  logic        ack_r;
  logic [31:0] rdat_r;
  bit          noack = 1'b0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      ack_r <= 1'b0;
    end else if (s_bus.stb && !ack_r && !noack) begin
      ack_r <= 1'b1;
      if (s_bus.we) mem[s_bus.adr[5:0]] <= merge(mem[s_bus.adr[5:0]], s_bus.wdat, s_bus.sel);
      else          rdat_r <= mem[s_bus.adr[5:0]];
    end else begin
      ack_r <= 1'b0;
    end
  end

  assign s_bus.ack  = ack_r;
  assign s_bus.rdat = rdat_r;
  assign s_bus.err  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard: every master ack must match the oldest expected access.
  always @(negedge clk) begin
    if (m0_bus.ack || m1_bus.ack) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected_ack actual=%b%b required=none", m1_bus.ack, m0_bus.ack);
      end else begin
        acc_t e;
        e = sbq.pop_front();
        chk("sb_grant", {31'd0, m1_bus.ack}, {31'd0, e.mst});
        chk("sb_adr", {2'b0, s_bus.adr}, {2'b0, e.adr});
        chk("sb_we", {31'd0, s_bus.we}, {31'd0, e.we});
        if (e.we) begin
          chk("sb_wdat", s_bus.wdat, e.dat);
          chk("sb_sel", {28'd0, s_bus.sel}, {28'd0, e.sel});
        end else begin
          chk("sb_rdat", e.mst ? m1_bus.rdat : m0_bus.rdat, e.rd);
        end
      end
    end
  end

  task automatic drive(input acc_t a);
    if (a.mst) begin
      m1_bus.stb = 1'b1; m1_bus.we = a.we; m1_bus.sel = a.sel;
      m1_bus.adr = a.adr; m1_bus.wdat = a.dat;
    end else begin
      m0_bus.stb = 1'b1; m0_bus.we = a.we; m0_bus.sel = a.sel;
      m0_bus.adr = a.adr; m0_bus.wdat = a.dat;
    end
  endtask

  task automatic drop(input bit mst);
    if (mst) m1_bus.stb = 1'b0;
    else     m0_bus.stb = 1'b0;
  endtask

  function automatic acc_t mk(input bit mst, input bit we, input logic [3:0] sel,
                              input logic [29:0] adr, input logic [31:0] dat,
                              input logic [31:0] rd);
    acc_t a;
    a.mst = mst; a.we = we; a.sel = sel; a.adr = adr; a.dat = dat; a.rd = rd;
    return a;
  endfunction

  // Waits (bounded) for the ack of master mst, then withdraws its strobe.
  task automatic wait_ack(input bit mst, input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mst ? m1_bus.ack : m0_bus.ack) begin
        seen = 1'b1;
        chk({nm, "_other_ack"}, {31'd0, mst ? m0_bus.ack : m1_bus.ack}, 32'd0);
      end
    end
    chk({nm, "_ack_seen"}, {31'd0, seen}, 32'd1);
    @(posedge clk); #1;
    drop(mst);
    @(negedge clk);
    chk({nm, "_ack_pulse"}, {31'd0, mst ? m1_bus.ack : m0_bus.ack}, 32'd0);
  endtask

  task automatic single(input acc_t a, input string nm);
    @(posedge clk); #1;
    drive(a);
    sbq.push_back(a);
    @(negedge clk);
    chk({nm, "_stb_lat0"}, {31'd0, s_bus.stb}, 32'd0);
    @(negedge clk);
    chk({nm, "_stb_lat1"}, {31'd0, s_bus.stb}, 32'd1);
    wait_ack(a.mst, nm);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation bound expired");
  end

  initial begin
    int acc0, acc1, done;
    bit a0, a1;

    tbl[0] = mk(0, 1, 4'hF, 30'h10, 32'hDEADBEEF, 32'h0);
    tbl[1] = mk(0, 0, 4'hF, 30'h10, 32'h0,        32'hDEADBEEF);
    tbl[2] = mk(1, 1, 4'hF, 30'h20, 32'hFFFFFFFF, 32'h0);
    tbl[3] = mk(1, 1, 4'h3, 30'h20, 32'h11223344, 32'h0);
    tbl[4] = mk(1, 0, 4'hF, 30'h20, 32'h0,        32'hFFFF3344);
    tbl[5] = mk(0, 1, 4'hF, 30'h21, 32'hA5A5A5A5, 32'h0);
    tbl[6] = mk(0, 1, 4'h3, 30'h21, 32'h00001234, 32'h0);
    tbl[7] = mk(1, 0, 4'hF, 30'h21, 32'h0,        32'hA5A51234);
    tbl[8] = mk(0, 0, 4'hF, 30'h10, 32'h0,        32'hDEADBEEF);

    // Reset: m0 fields non-zero and m1 requesting, yet the RAM side must be quiet.
    m0_bus.stb = 1'b0; m0_bus.we = 1'b1; m0_bus.sel = 4'hF;
    m0_bus.adr = 30'h3FF; m0_bus.wdat = 32'hCAFEF00D;
    m1_bus.stb = 1'b1; m1_bus.we = 1'b0; m1_bus.sel = 4'h0;
    m1_bus.adr = 30'h0; m1_bus.wdat = 32'h0;
    #1 rst = 1'b1;
    #2;
    chk("rst_s_stb", {31'd0, s_bus.stb}, 32'd0);
    chk("rst_s_we", {31'd0, s_bus.we}, 32'd0);
    chk("rst_s_sel", {28'd0, s_bus.sel}, 32'd0);
    chk("rst_s_adr", {2'b0, s_bus.adr}, 32'd0);
    chk("rst_s_wdat", s_bus.wdat, 32'd0);
    chk("rst_acks", {30'd0, m1_bus.ack, m0_bus.ack}, 32'd0);
    chk("rst_errs", {30'd0, m1_bus.err, m0_bus.err}, 32'd0);
    m1_bus.stb = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Contention from reset: both hold requests for six accesses, grants alternate from m0.
    acc0 = 0; acc1 = 0; done = 0;
    @(posedge clk); #1;
    drive(mk(0, 1, 4'hF, 30'h1, 32'hA0, 32'h0));
    drive(mk(1, 1, 4'hF, 30'h5, 32'hB0, 32'h0));
    for (int i = 0; i < 3; i++) begin
      sbq.push_back(mk(0, 1, 4'hF, 30'(1 + i), 32'(32'hA0 + i), 32'h0));
      sbq.push_back(mk(1, 1, 4'hF, 30'(5 + i), 32'(32'hB0 + i), 32'h0));
    end
    for (int cyc = 0; cyc < 100 && done < 6; cyc++) begin
      @(negedge clk);
      a0 = m0_bus.ack; a1 = m1_bus.ack;
      if (a0 || a1) begin
        done++;
        @(posedge clk); #1;
        if (a0) begin
          acc0++;
          if (acc0 == 3) m0_bus.stb = 1'b0;
          else begin m0_bus.adr = 30'(1 + acc0); m0_bus.wdat = 32'(32'hA0 + acc0); end
        end
        if (a1) begin
          acc1++;
          if (acc1 == 3) m1_bus.stb = 1'b0;
          else begin m1_bus.adr = 30'(5 + acc1); m1_bus.wdat = 32'(32'hB0 + acc1); end
        end
      end
    end
    chk("cont_done", done, 32'd6);

    // Single accesses, including byte-lane merges and read-back.
    for (int i = 0; i < 9; i++) single(tbl[i], $sformatf("tbl%0d", i));

    // Timeout on m1 (last completion was m0), then m0 must win the tie.
    noack = 1'b1;
    @(posedge clk); #1;
    drive(mk(1, 1, 4'hF, 30'h30, 32'h33330000, 32'h0));
    @(posedge clk); #1;
    drive(mk(0, 1, 4'hF, 30'h31, 32'h44440000, 32'h0));
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c < 4) begin
        chk($sformatf("to_noerr%0d", c), {31'd0, m1_bus.err}, 32'd0);
        chk($sformatf("to_stb%0d", c), {31'd0, s_bus.stb}, 32'd1);
      end else begin
        chk("to_err", {31'd0, m1_bus.err}, 32'd1);
        chk("to_err_stb", {31'd0, s_bus.stb}, 32'd0);
        chk("to_err_ack", {30'd0, m1_bus.ack, m0_bus.ack}, 32'd0);
        chk("to_m0_err", {31'd0, m0_bus.err}, 32'd0);
      end
    end
    @(posedge clk); #1;
    noack = 1'b0;
    sbq.push_back(mk(0, 1, 4'hF, 30'h31, 32'h44440000, 32'h0));
    sbq.push_back(mk(1, 1, 4'hF, 30'h30, 32'h33330000, 32'h0));
    @(negedge clk);
    chk("to_err_pulse", {31'd0, m1_bus.err}, 32'd0);
    wait_ack(0, "to_m0");
    wait_ack(1, "to_m1");

    // Withdrawal with prio=0 must leave prio alone: m0 wins the following tie.
    noack = 1'b1;
    @(posedge clk); #1;
    drive(mk(0, 1, 4'hF, 30'h08, 32'h0, 32'h0));
    @(posedge clk); #1;
    drop(0);
    @(negedge clk);
    chk("wd_a_stb", {31'd0, s_bus.stb}, 32'd0);
    chk("wd_a_noack", {31'd0, m0_bus.ack}, 32'd0);
    @(posedge clk); #1;
    noack = 1'b0;
    drive(mk(0, 1, 4'hF, 30'h08, 32'h88888888, 32'h0));
    drive(mk(1, 1, 4'hF, 30'h09, 32'h99999999, 32'h0));
    sbq.push_back(mk(0, 1, 4'hF, 30'h08, 32'h88888888, 32'h0));
    sbq.push_back(mk(1, 1, 4'hF, 30'h09, 32'h99999999, 32'h0));
    wait_ack(0, "wd_a_m0");
    wait_ack(1, "wd_a_m1");

    // Withdrawal with m1 pending: IDLE next edge, m1 granted the edge after.
    noack = 1'b1;
    @(posedge clk); #1;
    drive(mk(0, 1, 4'hF, 30'h0A, 32'h0, 32'h0));
    @(posedge clk); #1;
    drive(mk(1, 0, 4'hF, 30'h20, 32'h0, 32'h0));
    @(posedge clk); #1;
    drop(0);
    @(negedge clk);
    chk("wd_b_stb_busy", {31'd0, s_bus.stb}, 32'd0);
    chk("wd_b_noack", {31'd0, m0_bus.ack}, 32'd0);
    @(negedge clk);
    chk("wd_b_stb_idle", {31'd0, s_bus.stb}, 32'd0);
    noack = 1'b0;
    sbq.push_back(mk(1, 0, 4'hF, 30'h20, 32'h0, 32'hFFFF3344));
    @(negedge clk);
    chk("wd_b_grant_stb", {31'd0, s_bus.stb}, 32'd1);
    chk("wd_b_grant_adr", {2'b0, s_bus.adr}, 32'h20);
    wait_ack(1, "wd_b_m1");

    // Asynchronous reset while BUSY on m1.
    noack = 1'b1;
    @(posedge clk); #1;
    drive(mk(1, 0, 4'hF, 30'h20, 32'h0, 32'h0));
    @(posedge clk);
    @(negedge clk);
    chk("ra_busy_stb", {31'd0, s_bus.stb}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ra_stb", {31'd0, s_bus.stb}, 32'd0);
    chk("ra_adr", {2'b0, s_bus.adr}, 32'd0);
    chk("ra_acks", {30'd0, m1_bus.ack, m0_bus.ack}, 32'd0);
    chk("ra_errs", {30'd0, m1_bus.err, m0_bus.err}, 32'd0);
    @(posedge clk); #1;
    noack = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    sbq.push_back(mk(1, 0, 4'hF, 30'h20, 32'h0, 32'hFFFF3344));
    @(negedge clk);
    chk("ra_idle_stb", {31'd0, s_bus.stb}, 32'd0);
    @(negedge clk);
    chk("ra_grant_stb", {31'd0, s_bus.stb}, 32'd1);
    wait_ack(1, "ra_m1");

    repeat (2) @(posedge clk);
    chk("sb_empty", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
